// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Arbiter FSM state encoding, default bus widths and a next-state helper.
package dmem_arb_pkg;

   localparam int DEF_AW       = 8;
   localparam int DEF_DW       = 8;
   localparam int DEF_MAX_LOCK = 16;
   localparam int STAT_W       = 16;

   // Who owned the memory port in the previous cycle.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CORE = 2'd1,
      HOST = 2'd2,
      LOCK = 2'd3
   } arb_state_e;

   // The state only records the last grant and whether the host asked to keep ownership.
   function automatic arb_state_e next_state_f(input logic gnt_core,
                                               input logic gnt_host,
                                               input logic host_lock);
      arb_state_e ns;
      ns = IDLE;
      if (gnt_core) begin
         ns = CORE;
      end else if (gnt_host) begin
         ns = host_lock ? LOCK : HOST;
      end
      return ns;
   endfunction

endpackage

// File: rtl/arb_stat_cnt.sv
// Saturating event counter used for core stall statistics.
// Only instantiated by dmem_arbiter when DMEM_ARB_STATS_EN is defined.
module arb_stat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Count up on each event and stick at all-ones instead of wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register; reset wins over any event in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core and a host (loader/bench).
// Grants are combinational and the access completes in the grant cycle.
// Round-robin between the two sides, with a bounded host burst lock.
// Optional stall statistics: define DMEM_ARB_STATS_EN to enable stall_cnt.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int MAX_LOCK = DEF_MAX_LOCK
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [AW-1:0]     core_addr,
   input  logic [DW-1:0]     core_wdata,
   output logic              core_ack,
   output logic              core_stall,
   output logic [DW-1:0]     core_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic              host_lock,
   input  logic [AW-1:0]     host_addr,
   input  logic [DW-1:0]     host_wdata,
   output logic              host_ack,
   output logic [DW-1:0]     host_rdata,
   output logic              mem_wr_en,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata,
   output logic [STAT_W-1:0] stall_cnt
);

   localparam int LCW = $clog2(MAX_LOCK + 1);
   localparam logic [LCW-1:0] LOCK_MAX_C = LCW'(MAX_LOCK);

   arb_state_e     state_q;
   arb_state_e     state_d;
   logic [LCW-1:0] lock_cnt_q;
   logic [LCW-1:0] lock_cnt_d;
   logic           gnt_core;
   logic           gnt_host;

   // Grant decision, next state and burst-length bookkeeping.
   always_comb begin
      gnt_core   = 1'b0;
      gnt_host   = 1'b0;
      lock_cnt_d = '0;
      // Nothing is granted while reset is high, so no write can slip through.
      if (!reset) begin
         if (core_req && !host_req) begin
            gnt_core = 1'b1;
         end else if (host_req && !core_req) begin
            gnt_host = 1'b1;
         end else if (core_req && host_req) begin
            unique case (state_q)
               CORE:    gnt_host = 1'b1;
               // A host that drops host_lock loses burst priority immediately and
               // is treated like an unlocked host (core goes next).
               LOCK:    if (host_lock && (lock_cnt_q < LOCK_MAX_C)) gnt_host = 1'b1;
                        else                                        gnt_core = 1'b1;
               default: gnt_core = 1'b1;
            endcase
         end
      end
      if (gnt_host && host_lock) begin
         lock_cnt_d = (lock_cnt_q == LOCK_MAX_C) ? LOCK_MAX_C : lock_cnt_q + 1'b1;
      end
      state_d = next_state_f(gnt_core, gnt_host, host_lock);
   end

   // FSM and lock counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   // Route the granted side onto the memory port; park the port at zero otherwise.
   always_comb begin
      mem_wr_en = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt_core) begin
         mem_wr_en = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else if (gnt_host) begin
         mem_wr_en = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   assign core_ack   = gnt_core;
   assign host_ack   = gnt_host;
   assign core_stall = core_req & ~gnt_core;
   assign core_rdata = mem_rdata;
   assign host_rdata = mem_rdata;

`ifdef DMEM_ARB_STATS_EN
   arb_stat_cnt #(
      .W(STAT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (core_stall),
      .cnt   (stall_cnt)
   );
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data memory.
// Expected stall_cnt depends on whether DMEM_ARB_STATS_EN is defined for the build.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

`ifdef DMEM_ARB_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req, core_we, core_ack, core_stall;
   logic [7:0]  core_addr, core_wdata, core_rdata;
   logic        host_req, host_we, host_lock, host_ack;
   logic [7:0]  host_addr, host_wdata, host_rdata;
   logic        mem_wr_en;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic [15:0] stall_cnt;

   logic [7:0]  mem [256];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .AW(8), .DW(8), .MAX_LOCK(16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_ack   (core_ack),
      .core_stall (core_stall),
      .core_rdata (core_rdata),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_lock  (host_lock),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .mem_wr_en  (mem_wr_en),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .stall_cnt  (stall_cnt)
   );

   // Behavioural dat_mem: combinational read, write on rising edge.
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr] <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_core(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
      core_req = r; core_we = w; core_addr = a; core_wdata = d;
   endtask

   task automatic set_host(input logic r, input logic w, input logic l,
                           input logic [7:0] a, input logic [7:0] d);
      host_req = r; host_we = w; host_lock = l; host_addr = a; host_wdata = d;
   endtask

   // Advance one clock: through the rising edge, back to the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      set_core(0, 0, 8'h00, 8'h00);
      set_host(0, 0, 0, 8'h00, 8'h00);
      step(); step();

      // Reset behaviour with both sides requesting and a host write pending.
      set_core(1, 0, 8'h10, 8'h00);
      set_host(1, 1, 1, 8'h05, 8'h77);
      #2;
      chk("rst_core_ack", 32'(core_ack), 0);
      chk("rst_host_ack", 32'(host_ack), 0);
      chk("rst_wr_en", 32'(mem_wr_en), 0);
      chk("rst_stall", 32'(core_stall), 1);
      step();
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      chk("rst_lock_cnt", 32'(dut.lock_cnt_q), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      reset = 1'b0;
      set_core(0, 0, 8'h00, 8'h00);
      set_host(0, 0, 0, 8'h00, 8'h00);

      // Core-only write then read back.
      set_core(1, 1, 8'h40, 8'hA5);
      #2;
      chk("cw_ack", 32'(core_ack), 1);
      chk("cw_stall", 32'(core_stall), 0);
      chk("cw_wr_en", 32'(mem_wr_en), 1);
      chk("cw_addr", 32'(mem_addr), 32'h40);
      chk("cw_wdata", 32'(mem_wdata), 32'hA5);
      chk("cw_host_ack", 32'(host_ack), 0);
      step();
      set_core(1, 0, 8'h40, 8'h00);
      #2;
      chk("cr_ack", 32'(core_ack), 1);
      chk("cr_stall", 32'(core_stall), 0);
      chk("cr_wr_en", 32'(mem_wr_en), 0);
      chk("cr_rdata", 32'(core_rdata), 32'hA5);
      step();

      // No request: memory port parked at zero even with live address/data inputs.
      set_core(0, 1, 8'h33, 8'h44);
      set_host(0, 1, 0, 8'h55, 8'h66);
      #2;
      chk("idle_wr_en", 32'(mem_wr_en), 0);
      chk("idle_addr", 32'(mem_addr), 0);
      chk("idle_wdata", 32'(mem_wdata), 0);
      chk("idle_stall", 32'(core_stall), 0);
      step();

      // Both request from IDLE, unlocked: core, host, core, host.
      set_core(1, 0, 8'h40, 8'h00);
      set_host(1, 0, 0, 8'h41, 8'h00);
      for (int i = 0; i < 4; i++) begin
         logic exp_c;
         exp_c = (i % 2 == 0);
         #2;
         chk($sformatf("rr_core_ack[%0d]", i), 32'(core_ack), 32'(exp_c));
         chk($sformatf("rr_host_ack[%0d]", i), 32'(host_ack), 32'(!exp_c));
         chk($sformatf("rr_stall[%0d]", i), 32'(core_stall), 32'(!exp_c));
         chk($sformatf("rr_addr[%0d]", i), 32'(mem_addr), exp_c ? 32'h40 : 32'h41);
         step();
      end
      set_core(0, 0, 8'h00, 8'h00);
      set_host(0, 0, 0, 8'h00, 8'h00);
      step();

      // Locked host burst writing 0..15, then a 17th locked write past saturation.
      for (int i = 0; i < 17; i++) begin
         set_host(1, 1, 1, 8'(i), 8'(i));
         #2;
         chk($sformatf("burst_ack[%0d]", i), 32'(host_ack), 1);
         chk($sformatf("burst_wr_en[%0d]", i), 32'(mem_wr_en), 1);
         step();
         if (i == 15) chk("burst_lock_cnt16", 32'(dut.lock_cnt_q), 16);
      end
      chk("burst_lock_sat", 32'(dut.lock_cnt_q), 16);
      chk("burst_state", 32'(dut.state_q), 32'(LOCK));
      for (int i = 0; i < 17; i++) begin
         set_host(1, 0, 0, 8'(i), 8'h00);
         #2;
         chk($sformatf("burst_rd[%0d]", i), 32'(host_rdata), 32'(i));
         step();
         if (i == 0) chk("unlock_lock_cnt", 32'(dut.lock_cnt_q), 0);
      end
      chk("unlock_state", 32'(dut.state_q), 32'(HOST));
      set_host(0, 0, 0, 8'h00, 8'h00);

      // Lock limit against a continuously requesting core; clear stall_cnt first.
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_core(1, 0, 8'h40, 8'h00);
      #2;
      chk("lim_pre_ack", 32'(core_ack), 1);
      step();
      set_host(1, 0, 1, 8'h80, 8'h00);
      for (int i = 0; i < 17; i++) begin
         logic exp_h;
         exp_h = (i < 16);
         #2;
         chk($sformatf("lim_host_ack[%0d]", i), 32'(host_ack), 32'(exp_h));
         chk($sformatf("lim_core_ack[%0d]", i), 32'(core_ack), 32'(!exp_h));
         chk($sformatf("lim_stall[%0d]", i), 32'(core_stall), 32'(exp_h));
         chk($sformatf("lim_stall_cnt[%0d]", i), 32'(stall_cnt), STATS ? 32'(i) : 0);
         step();
      end
      chk("lim_stall_cnt_end", 32'(stall_cnt), STATS ? 32'd16 : 0);
      chk("lim_state", 32'(dut.state_q), 32'(CORE));
      chk("lim_lock_cnt", 32'(dut.lock_cnt_q), 0);

      // Host drops lock mid-burst: priority ends on the very next decision.
      #2;
      chk("drop_host_first", 32'(host_ack), 1);
      step();
      set_host(1, 0, 0, 8'h80, 8'h00);
      #2;
      chk("drop_core_ack", 32'(core_ack), 1);
      chk("drop_host_ack", 32'(host_ack), 0);
      step();
      set_core(0, 0, 8'h00, 8'h00);
      set_host(0, 0, 0, 8'h00, 8'h00);

      // Reset in cycle 5 of a locked host write burst.
      set_core(1, 1, 8'h95, 8'h5A);
      step();
      set_core(0, 0, 8'h00, 8'h00);
      for (int i = 0; i < 6; i++) begin
         set_host(1, 1, 1, 8'h90 + 8'(i), 8'hE0 + 8'(i));
         if (i == 5) reset = 1'b1;
         #2;
         if (i == 5) begin
            chk("rb_wr_en", 32'(mem_wr_en), 0);
            chk("rb_host_ack", 32'(host_ack), 0);
         end else begin
            chk($sformatf("rb_ack[%0d]", i), 32'(host_ack), 1);
         end
         step();
      end
      reset = 1'b0;
      chk("rb_state", 32'(dut.state_q), 32'(IDLE));
      chk("rb_lock_cnt", 32'(dut.lock_cnt_q), 0);
      set_host(1, 0, 0, 8'h95, 8'h00);
      #2;
      chk("rb_no_write", 32'(host_rdata), 32'h5A);
      step();
      set_host(1, 0, 0, 8'h94, 8'h00);
      #2;
      chk("rb_last_write", 32'(host_rdata), 32'hE4);
      step();
      set_host(0, 0, 0, 8'h00, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- AW, 8, data-memory address width.
- DW, 8, data-memory data width.
- MAX_LOCK, 16, maximum consecutive locked host grants while the core waits.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- core_req  in  1  core memory access request (load/store).
- core_we  in  1  core write enable.
- core_addr  in  AW  core address.
- core_wdata  in  DW  core store data.
- core_ack  out  1  core access performed this cycle.
- core_stall  out  1  core_req high and not acked; core holds PC.
- core_rdata  out  DW  read data to core.
- host_req  in  1  host (loader/bench) access request.
- host_we  in  1  host write enable.
- host_lock  in  1  host requests burst ownership.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_ack  out  1  host access performed this cycle.
- host_rdata  out  DW  read data to host.
- mem_wr_en  out  1  to dat_mem wr_en.
- mem_addr  out  AW  to dat_mem addr.
- mem_wdata  out  DW  to dat_mem dat_in.
- mem_rdata  in  DW  from dat_mem dat_out (combinational read).
- stall_cnt  out  16  core stall-cycle count (see Configuration).

Function
REQ-003 SHALL grant at most one requester per cycle; a grant is combinational from the current req inputs and the registered state, and the access completes in the same cycle.
REQ-004 SHALL assert the granted side's ack in the grant cycle and drive mem_addr/mem_wdata/mem_wr_en from that side; mem_wr_en = granted we.
REQ-005 SHALL drive core_rdata and host_rdata from mem_rdata unconditionally; data is valid only when the matching ack is high.
REQ-006 SHALL drive mem_wr_en=0, mem_addr=0, mem_wdata=0 when no grant.
REQ-007 SHALL hold an FSM with states IDLE (no grant last cycle), CORE (core granted last), HOST (host granted last, unlocked), and LOCK (host granted last with host_lock).
REQ-008 SHALL grant the sole requester when only one requests.
REQ-009 SHALL resolve both requesting outside LOCK round-robin as follows:
- From IDLE or HOST, grant core.
- From CORE, grant host.
REQ-010 SHALL, in LOCK with both requesting, grant host while lock_cnt < MAX_LOCK, else grant core.
REQ-011 SHALL drive lock_cnt as follows:
- Increment on each host grant with host_lock=1.
- Clear on any core grant, on a host grant with host_lock=0, and on an idle cycle.
- Saturate at MAX_LOCK.
REQ-012 SHALL set next state as follows:
- Core grant → CORE.
- Host grant with host_lock → LOCK.
- Host grant without host_lock → HOST.
- No grant → IDLE.
REQ-013 SHALL assert core_stall = core_req & ~core_ack; the core SHALL hold req/addr/we/wdata stable while stalled.
REQ-014 SHALL make a host deasserting host_lock mid-burst end LOCK on the next grant decision; no extra cycle.

Reset
REQ-015 SHALL, while reset is high, set state=IDLE, lock_cnt=0, stall_cnt=0, and force core_ack=host_ack=0, mem_wr_en=0, core_stall=core_req.
REQ-016 SHALL, when reset is asserted mid-burst, abandon LOCK at the next edge; no write occurs in a reset cycle.

Configuration
REQ-017 SHALL, with DMEM_ARB_STATS_EN defined, increment stall_cnt on each non-reset cycle with core_stall=1, saturating at 16'hFFFF.
REQ-018 SHALL, with DMEM_ARB_STATS_EN undefined, tie stall_cnt to 0, with no counter logic.

Structure
REQ-019 SHALL place the state enum (IDLE, CORE, HOST, LOCK) and default AW/DW in shared package dmem_arb_pkg.
REQ-020 SHALL implement the saturating stall counter as sub-module arb_stat_cnt, instantiated only under DMEM_ARB_STATS_EN.

Verification
REQ-021 SHALL cover: core-only write addr 8'h40 data 8'hA5, then read → core_ack each cycle, core_rdata=8'hA5, core_stall=0.
REQ-022 SHALL cover: both request from IDLE for 4 cycles, no lock → grants core,host,core,host; core_stall high in cycles 2 and 4.
REQ-023 SHALL cover: host_lock=1 with continuous core_req, MAX_LOCK=16 → 16 host grants, then a core grant on the 17th cycle, stall_cnt=16 (stats on).
REQ-024 SHALL cover: host writes 8'h00..8'h0F to addresses 0..15 locked, no core_req → 16 consecutive host_ack, memory contents match.
REQ-025 SHALL cover: reset asserted during a host write burst at cycle 5 → no mem_wr_en in reset cycle, state IDLE after, lock_cnt=0.
REQ-026 SHALL cover: build without DMEM_ARB_STATS_EN, scenario REQ-023 → stall_cnt=0 throughout, grants unchanged.
